// File: rtl/dps_irq_pkg.sv
// Shared constants, FSM state and configuration-entry types for the DPS
// interrupt controller.
package dps_irq_pkg;

    localparam int P_IRQ_N   = 64;
    localparam int P_IRQ_W   = 6;
    localparam int P_LEVEL_W = 2;

    // First IRQ table entry assigned to each device group
    localparam logic [P_IRQ_W-1:0] UTIM64_IRT_BASE  = 6'd36;
    localparam logic [P_IRQ_W-1:0] LSFLAGS_IRT_BASE = 6'd38;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        REQ
    } irq_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 mask;
        logic [P_LEVEL_W-1:0] level;
    } irq_cfg_t;

endpackage

// File: rtl/dps_irq_prio_select.sv
// Combinational arbiter: lowest level value wins, ties go to the lowest
// entry number.
module dps_irq_prio_select
    import dps_irq_pkg::*;
(
    input  logic [P_IRQ_N-1:0]                eligible,
    input  logic [P_IRQ_N-1:0][P_LEVEL_W-1:0] levels,
    output logic                              found,
    output logic [P_IRQ_W-1:0]                num
);

    logic [P_LEVEL_W-1:0] bestLevel;

    // NOTE: blocking assignments are intended here; each loop iteration
    // must see the running best found by the iterations before it.
    always_comb begin
        found     = 1'b0;
        num       = '0;
        bestLevel = '0;
        // Strict less-than keeps the lower entry number on equal levels
        for (int n = 0; n < P_IRQ_N; n++) begin
            if (eligible[n] && (!found || (levels[n] < bestLevel))) begin
                found     = 1'b1;
                num       = P_IRQ_W'(n);
                bestLevel = levels[n];
            end
        end
    end

endmodule

// File: rtl/dps_irq_controller.sv
// DPS interrupt controller: latches device events into a pending vector,
// gates them with the config table and hands one request at a time to the core.
module dps_irq_controller
    import dps_irq_pkg::*;
(
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic [P_IRQ_N-1:0]   iIRQ_EVENT,
    input  logic                 iDPS_IRQ_CONFIG_TABLE_REQ,
    input  logic [P_IRQ_W-1:0]   iDPS_IRQ_CONFIG_TABLE_ENTRY,
    input  logic                 iDPS_IRQ_CONFIG_TABLE_FLAG_VALID,
    input  logic                 iDPS_IRQ_CONFIG_TABLE_FLAG_MASK,
    input  logic [P_LEVEL_W-1:0] iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL,
    output logic                 oDPS_IRQ_REQ,
    output logic [P_IRQ_W-1:0]   oDPS_IRQ_NUM,
    input  logic                 iDPS_IRQ_ACK
);

    irq_cfg_t                          cfgTable [P_IRQ_N];
    logic [P_IRQ_N-1:0]                pending;
    logic [P_IRQ_N-1:0]                pendingNext;
    logic [P_IRQ_N-1:0]                eligible;
    logic [P_IRQ_N-1:0][P_LEVEL_W-1:0] levels;
    irq_state_t                        state;
    irq_state_t                        stateNext;
    logic [P_IRQ_W-1:0]                irqNum;
    logic [P_IRQ_W-1:0]                irqNumNext;
    logic                              selFound;
    logic [P_IRQ_W-1:0]                selNum;
    logic                              ackClear;

    always_comb begin
        for (int n = 0; n < P_IRQ_N; n++) begin
            eligible[n] = pending[n] & cfgTable[n].valid & cfgTable[n].mask;
            levels[n]   = cfgTable[n].level;
        end
    end

    dps_irq_prio_select uPrioSelect (
        .eligible (eligible),
        .levels   (levels),
        .found    (selFound),
        .num      (selNum)
    );

    // Event set overrides the ACK clear; invalidating an entry overrides both.
    // Event acceptance uses the table as it stood before this cycle's write.
    always_comb begin
        ackClear = (state == REQ) && iDPS_IRQ_ACK;
        for (int n = 0; n < P_IRQ_N; n++) begin
            pendingNext[n] = pending[n];
            if (ackClear && (irqNum == P_IRQ_W'(n)))
                pendingNext[n] = 1'b0;
            if (iIRQ_EVENT[n] && cfgTable[n].valid)
                pendingNext[n] = 1'b1;
            if (iDPS_IRQ_CONFIG_TABLE_REQ && !iDPS_IRQ_CONFIG_TABLE_FLAG_VALID
                && (iDPS_IRQ_CONFIG_TABLE_ENTRY == P_IRQ_W'(n)))
                pendingNext[n] = 1'b0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        stateNext  = state;
        irqNumNext = irqNum;
        unique case (state)
            IDLE: begin
                if (selFound) begin
                    stateNext  = SELECT;
                    irqNumNext = selNum;
                end
            end
            SELECT: stateNext = eligible[irqNum] ? REQ : IDLE;
            REQ: begin
                if (iDPS_IRQ_ACK)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state   <= IDLE;
            irqNum  <= '0;
            pending <= '0;
            // NOTE: the table is built from flops, not a RAM macro, and it
            // must come out of reset all-invalid, so every entry is cleared.
            for (int n = 0; n < P_IRQ_N; n++)
                cfgTable[n] <= '0;
        end else begin
            state   <= stateNext;
            irqNum  <= irqNumNext;
            pending <= pendingNext;
            if (iDPS_IRQ_CONFIG_TABLE_REQ)
                cfgTable[iDPS_IRQ_CONFIG_TABLE_ENTRY] <= '{
                    valid: iDPS_IRQ_CONFIG_TABLE_FLAG_VALID,
                    mask:  iDPS_IRQ_CONFIG_TABLE_FLAG_MASK,
                    level: iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL
                };
        end
    end

    assign oDPS_IRQ_REQ = (state == REQ);
    assign oDPS_IRQ_NUM = irqNum;

endmodule

// File: tb/tb_dps_irq_controller.sv
// Scoreboard bench for dps_irq_controller: expected request numbers are queued
// as stimulus is driven and popped whenever the request line rises.
module tb_dps_irq_controller;
    import dps_irq_pkg::*;

    logic                 iCLOCK;
    logic                 inRESET;
    logic [P_IRQ_N-1:0]   iIRQ_EVENT;
    logic                 iDPS_IRQ_CONFIG_TABLE_REQ;
    logic [P_IRQ_W-1:0]   iDPS_IRQ_CONFIG_TABLE_ENTRY;
    logic                 iDPS_IRQ_CONFIG_TABLE_FLAG_VALID;
    logic                 iDPS_IRQ_CONFIG_TABLE_FLAG_MASK;
    logic [P_LEVEL_W-1:0] iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL;
    logic                 oDPS_IRQ_REQ;
    logic [P_IRQ_W-1:0]   oDPS_IRQ_NUM;
    logic                 iDPS_IRQ_ACK;

    int total = 0;
    int bad   = 0;
    logic [P_IRQ_W-1:0] expQ[$];
    logic reqPrev = 1'b0;

    localparam int E36 = int'(UTIM64_IRT_BASE);
    localparam int E37 = int'(UTIM64_IRT_BASE) + 1;

    dps_irq_controller dut (
        .iCLOCK                           (iCLOCK),
        .inRESET                          (inRESET),
        .iIRQ_EVENT                       (iIRQ_EVENT),
        .iDPS_IRQ_CONFIG_TABLE_REQ        (iDPS_IRQ_CONFIG_TABLE_REQ),
        .iDPS_IRQ_CONFIG_TABLE_ENTRY      (iDPS_IRQ_CONFIG_TABLE_ENTRY),
        .iDPS_IRQ_CONFIG_TABLE_FLAG_VALID (iDPS_IRQ_CONFIG_TABLE_FLAG_VALID),
        .iDPS_IRQ_CONFIG_TABLE_FLAG_MASK  (iDPS_IRQ_CONFIG_TABLE_FLAG_MASK),
        .iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL (iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL),
        .oDPS_IRQ_REQ                     (oDPS_IRQ_REQ),
        .oDPS_IRQ_NUM                     (oDPS_IRQ_NUM),
        .iDPS_IRQ_ACK                     (iDPS_IRQ_ACK)
    );

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [P_IRQ_N-1:0] bitOf(input int n);
        logic [P_IRQ_N-1:0] one;
        one = 1;
        return one << n;
    endfunction

    // Inputs change 1ns after the rising edge; the DUT samples them at the next edge
    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic writeCfg(input int entry, input logic valid, input logic mask,
                            input logic [P_LEVEL_W-1:0] level);
        iDPS_IRQ_CONFIG_TABLE_REQ        = 1'b1;
        iDPS_IRQ_CONFIG_TABLE_ENTRY      = P_IRQ_W'(entry);
        iDPS_IRQ_CONFIG_TABLE_FLAG_VALID = valid;
        iDPS_IRQ_CONFIG_TABLE_FLAG_MASK  = mask;
        iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL = level;
        tick();
        iDPS_IRQ_CONFIG_TABLE_REQ        = 1'b0;
    endtask

    task automatic pulseEvent(input logic [P_IRQ_N-1:0] ev);
        iIRQ_EVENT = ev;
        tick();
        iIRQ_EVENT = '0;
    endtask

    task automatic pulseAck();
        iDPS_IRQ_ACK = 1'b1;
        tick();
        iDPS_IRQ_ACK = 1'b0;
    endtask

    // Counts edges from the stimulus edge until REQ shows; bounded at 10
    task automatic waitReq(input string tag);
        int lat;
        lat = 0;
        while (!oDPS_IRQ_REQ && lat < 10) begin
            tick();
            lat++;
        end
        check(tag, 64'(lat), 64'd2);
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            saw = saw | oDPS_IRQ_REQ;
        end
        check(tag, 64'(saw), 64'd0);
    endtask

    // Scoreboard side: each rising REQ must match the oldest expected entry
    always @(negedge iCLOCK) begin
        if (oDPS_IRQ_REQ && !reqPrev) begin
            if (expQ.size() == 0)
                check("unexpected_req", 64'(oDPS_IRQ_REQ), 64'd0);
            else
                check("req_num", 64'(oDPS_IRQ_NUM), 64'(expQ.pop_front()));
        end
        reqPrev = oDPS_IRQ_REQ;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        inRESET                          = 1'b0;
        iIRQ_EVENT                       = '0;
        iDPS_IRQ_CONFIG_TABLE_REQ        = 1'b0;
        iDPS_IRQ_CONFIG_TABLE_ENTRY      = '0;
        iDPS_IRQ_CONFIG_TABLE_FLAG_VALID = 1'b0;
        iDPS_IRQ_CONFIG_TABLE_FLAG_MASK  = 1'b0;
        iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL = '0;
        iDPS_IRQ_ACK                     = 1'b0;
        repeat (3) tick();
        check("reset_req", 64'(oDPS_IRQ_REQ), 64'd0);
        check("reset_num", 64'(oDPS_IRQ_NUM), 64'd0);
        inRESET = 1'b1;
        quiet("idle_after_reset", 5);

        // Same level: lower entry number first
        writeCfg(E36, 1'b1, 1'b1, 2'd0);
        writeCfg(E37, 1'b1, 1'b1, 2'd0);
        expQ.push_back(P_IRQ_W'(E36));
        expQ.push_back(P_IRQ_W'(E37));
        pulseEvent(bitOf(E36) | bitOf(E37));
        waitReq("tie_first_latency");
        pulseAck();
        check("tie_ack_drop", 64'(oDPS_IRQ_REQ), 64'd0);
        check("tie_num_hold", 64'(oDPS_IRQ_NUM), 64'(E36));
        waitReq("tie_second_latency");
        pulseAck();
        quiet("tie_done_quiet", 8);

        // Lower level value wins; repeated events before ACK merge
        writeCfg(E36, 1'b1, 1'b1, 2'd2);
        writeCfg(E37, 1'b1, 1'b1, 2'd0);
        expQ.push_back(P_IRQ_W'(E37));
        expQ.push_back(P_IRQ_W'(E36));
        pulseEvent(bitOf(E36) | bitOf(E37));
        waitReq("level_first_latency");
        pulseEvent(bitOf(E37));
        tick();
        pulseEvent(bitOf(E37));
        check("merge_req_held", 64'(oDPS_IRQ_REQ), 64'd1);
        pulseAck();
        waitReq("level_second_latency");
        pulseAck();
        quiet("level_done_quiet", 8);

        // Masked pending bit is held, stray ACK while idle is ignored
        writeCfg(5, 1'b1, 1'b0, 2'd1);
        pulseEvent(bitOf(5));
        quiet("masked_quiet", 20);
        pulseAck();
        quiet("stray_ack_quiet", 3);
        expQ.push_back(P_IRQ_W'(5));
        writeCfg(5, 1'b1, 1'b1, 2'd1);
        waitReq("unmask_latency");
        pulseAck();
        quiet("unmask_done_quiet", 8);

        // Event on an invalid entry is dropped
        writeCfg(10, 1'b0, 1'b0, 2'd0);
        pulseEvent(bitOf(10));
        writeCfg(10, 1'b1, 1'b1, 2'd0);
        quiet("invalid_dropped", 10);

        // ACK and a new event on the same entry together: entry re-requests
        writeCfg(E36, 1'b1, 1'b1, 2'd0);
        expQ.push_back(P_IRQ_W'(E36));
        pulseEvent(bitOf(E36));
        waitReq("collide_first_latency");
        expQ.push_back(P_IRQ_W'(E36));
        iDPS_IRQ_ACK = 1'b1;
        iIRQ_EVENT   = bitOf(E36);
        tick();
        iDPS_IRQ_ACK = 1'b0;
        iIRQ_EVENT   = '0;
        check("collide_drop", 64'(oDPS_IRQ_REQ), 64'd0);
        waitReq("collide_rereq_latency");
        pulseAck();
        quiet("collide_done_quiet", 8);

        // Reset while requesting clears request, pending and table
        expQ.push_back(P_IRQ_W'(E37));
        pulseEvent(bitOf(E37));
        waitReq("prereset_latency");
        inRESET = 1'b0;
        tick();
        inRESET = 1'b1;
        check("midreset_req", 64'(oDPS_IRQ_REQ), 64'd0);
        check("midreset_num", 64'(oDPS_IRQ_NUM), 64'd0);
        pulseAck();
        pulseEvent(bitOf(E36) | bitOf(E37));
        quiet("table_cleared_quiet", 8);
        writeCfg(E37, 1'b1, 1'b1, 2'd0);
        quiet("pending_cleared_quiet", 8);

        check("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
